// File: rtl/acc_pkg.sv
// acc_pkg: shared widths and FSM state encodings for the accumulator and its BCD display converter.
package acc_pkg;

  localparam int ACC_W       = 8;
  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/acc_bcd_if.sv
// acc_bcd_if: start/busy/done handshake plus data and result buses of the BCD converter.
interface acc_bcd_if
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W,
  parameter int NDIG  = 3
) ();

  logic                       start;
  logic [WIDTH-1:0]           din;
  logic                       busy;
  logic                       done;
  logic [BCD_DIGIT_W*NDIG-1:0] bcd;

  modport master (output start, output din, input busy, input done, input bcd);
  modport slave  (input start, input din, output busy, output done, output bcd);

endinterface

// File: rtl/acc_bcd_add3.sv
// bcd_add3: double-dabble digit correction, out = (in >= 5) ? in + 3 : in.
module bcd_add3
  import acc_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_dig,
  output logic [BCD_DIGIT_W-1:0] o_dig
);

  assign o_dig = (i_dig >= 4'd5) ? i_dig + 4'd3 : i_dig;

endmodule

// File: rtl/acc_bcd.sv
// acc_bcd: binary-to-packed-BCD converter, one bit per clock (shift-add-3).
// Optional macro ACC_BCD_AUTO_START_EN: start a conversion whenever din differs from the last accepted value.
`default_nettype none
module acc_bcd
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W,
  parameter int NDIG  = 3
) (
  input  logic        clk,
  input  logic        r,
  acc_bcd_if.slave    bus
);

  localparam int SW = BCD_DIGIT_W * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_trig;
  logic [WIDTH-1:0] r_shreg;
  logic [SW-1:0]    r_scratch;
  logic [SW-1:0]    w_adj;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_bcd;
  logic             r_done;

  genvar gi;
  generate
    for (gi = 0; gi < NDIG; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .i_dig (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_dig (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

`ifdef ACC_BCD_AUTO_START_EN
  logic [WIDTH-1:0] r_last_din;

  // A changed input behaves exactly like an explicit start request.
  assign w_trig = bus.start | (bus.din != r_last_din);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_last_din <= '0;
    end else if (w_accept) begin
      r_last_din <= bus.din;
    end
  end
`else
  assign w_trig = bus.start;
`endif

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_count == CW'(1)) begin
          w_state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_FINISH);
      if (w_accept) begin
        r_shreg   <= bus.din;
        r_scratch <= '0;
        r_count   <= CW'(WIDTH);
      end else if (r_state == ST_SHIFT) begin
        // Corrected digits shift left; the binary MSB enters the ones digit.
        r_scratch <= {w_adj[SW-2:0], r_shreg[WIDTH-1]};
        r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
        r_count   <= r_count - CW'(1);
      end
      if (r_state == ST_FINISH) begin
        r_bcd <= r_scratch;
      end
    end
  end

  assign bus.busy = (r_state != ST_IDLE);
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule
`default_nettype wire
